rgmii_tx: RTL
=============

Name: rgmii_tx

Overview:
RGMII MAC transmit engine: takes a byte stream (valid/last/ready) in the 125 MHz domain and emits framed Ethernet on RGMII as per-edge nibble/ctrl pairs for downstream ODDR primitives. It inserts preamble/SFD, optionally pads, appends CRC-32 FCS, and enforces inter-frame gap. It fills the TX side of the rgmii top level, mirroring rgmii_rx.

Parameters:
PREAMBLE_BYTES, 7, count of 0x55 bytes before SFD (legal 1..7)
MIN_FRAME_BYTES, 60, minimum data+pad length excluding FCS (used only with padding)
IFG_BYTES, 12, idle byte-times after last FCS byte before next frame may start

Ports:
clk125In  input  1  125 MHz TX clock, one byte-time per cycle
rstIn  input  1  asynchronous active-high reset
mmcmLockedIn  input  1  clock-good; no new frame starts while low
txDataIn  input  8  payload byte (DA first)
txDataValidIn  input  1  txDataIn valid
txDataLastIn  input  1  final payload byte of frame, qualified by valid
txReadyOut  output  1  byte accepted when valid&ready
txDataRiseOut  output  4  nibble for rising edge = byte[3:0]
txDataFallOut  output  4  nibble for falling edge = byte[7:4]
txCtrlRiseOut  output  1  TX_EN
txCtrlFallOut  output  1  TX_EN xor TX_ER
txBusyOut  output  1  high in any state except IDLE
txUnderrunOut  output  1  one-cycle pulse on underrun detection

Behaviour:
- One clock, clk125In; reset is asynchronous and active-high on rstIn. All outputs registered; during reset all outputs 0, state IDLE, CRC=0xFFFFFFFF.
- States: IDLE -> PREAMBLE -> SFD -> DATA -> [PAD] -> FCS -> IFG -> IDLE; DATA -> ERR -> DRAIN -> IFG on underrun.
- IDLE: ctrl=0/0, data=0. If txDataValidIn & mmcmLockedIn -> PREAMBLE (byte not consumed; ready stays 0).
- PREAMBLE: PREAMBLE_BYTES cycles of 0x55, ctrl=1/1. SFD: one cycle 0xD5, ctrl=1/1. txReadyOut asserts combinationally-registered so it is 1 in the first DATA cycle.
- DATA: txReadyOut=1. Accepted byte appears on outputs next cycle (latency 1), ctrl=1/1; CRC and 16-bit byte counter updated. On accepted last: if padding compiled in and count<MIN_FRAME_BYTES -> PAD else FCS; ready drops same cycle as last is accepted... i.e. ready=0 in the following cycle.
- Underrun: valid=0 in DATA -> ERR for one cycle: data=0x00, ctrlRise=1, ctrlFall=0 (TX_ER), txUnderrunOut pulse; then DRAIN: ctrl=0, ready=1, discard bytes until last accepted (if last was never seen, wait indefinitely); then IFG. No FCS sent.
- PAD: emit 0x00 each cycle (CRC updated) until count==MIN_FRAME_BYTES.
- FCS: 4 cycles; CRC-32 reflected poly 0xEDB88320, init 0xFFFFFFFF, over data+pad (not preamble/SFD); send ~CRC LSB byte first.
- IFG: ctrl=0, data=0 for exactly IFG_BYTES cycles, ignoring input; then IDLE (next frame's preamble starts earliest 1 cycle later).
- mmcmLockedIn falling mid-frame: ignored; frame completes. Async reset mid-frame: outputs 0 immediately, frame lost.
- Byte counter saturates at 0xFFFF; no max-length enforcement.

Optional Feature:
RGMII_TX_PAD_EN: defined -> frames with <MIN_FRAME_BYTES data bytes zero-padded to MIN_FRAME_BYTES before FCS, pad included in CRC. Undefined -> PAD state absent; DATA->FCS directly regardless of length.

Test Plan:
- PAD off, payload ASCII "123456789" (0x31..0x39) -> wire: 7x0x55, 0xD5, 9 data bytes, FCS 0x26,0x39,0xF4,0xCB, ctrl 1/1 throughout, then 12 idle cycles.
- PAD on, 14-byte frame -> 14 data + 46 0x00 bytes, 4 FCS bytes matching software CRC of 60-byte buffer; total TX_EN cycles 8+60+4=72.
- Back-to-back frames with valid held high -> exactly 12 ctrl=0 cycles between last FCS byte and next 0x55.
- Valid drop on byte 20 of 64 -> one cycle ctrlRise=1/ctrlFall=0 data 0x00, txUnderrunOut=1 for 1 cycle, no FCS, remaining bytes drained until last, then 12-cycle IFG.
- mmcmLockedIn=0 with valid=1 -> stays IDLE, txBusyOut=0; locked rises -> preamble next cycle.
- Assert rstIn during DATA -> all outputs 0 same cycle; after release with valid=1 a clean new frame begins with preamble.

Source files
------------

// File: rtl/rgmii_tx.sv
// rgmii_tx: RGMII MAC transmitter that frames a byte stream with preamble/SFD, CRC-32 FCS and inter-frame gap.
// Define RGMII_TX_PAD_EN to zero-pad short frames up to MIN_FRAME_BYTES before the FCS.
module rgmii_tx #(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_BYTES       = 12
) (
    input  logic       clk125In,
    input  logic       rstIn,
    input  logic       mmcmLockedIn,
    input  logic [7:0] txDataIn,
    input  logic       txDataValidIn,
    input  logic       txDataLastIn,
    output logic       txReadyOut,
    output logic [3:0] txDataRiseOut,
    output logic [3:0] txDataFallOut,
    output logic       txCtrlRiseOut,
    output logic       txCtrlFallOut,
    output logic       txBusyOut,
    output logic       txUnderrunOut
);
    localparam logic [15:0] PRE_L = 16'(PREAMBLE_BYTES);
    localparam logic [15:0] IFG_L = 16'(IFG_BYTES);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_FCS, S_IFG, S_ERR, S_DRAIN
`ifdef RGMII_TX_PAD_EN
        , S_PAD
`endif
    } state_t;

    state_t      state_q, state_d, data_done;
    logic [15:0] cnt_q, cnt_d, len_q, len_d, len_inc;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  byte_q, byte_d;
    logic        en_q, en_d, er_d, fall_q;
    logic        ready_q, ready_d, busy_q, busy_d, under_q, under_d;
    logic        go;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign go      = txDataValidIn & mmcmLockedIn;
    assign len_inc = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

`ifdef RGMII_TX_PAD_EN
    localparam logic [15:0] MIN_L = 16'(MIN_FRAME_BYTES);
    assign data_done = (len_inc < MIN_L) ? S_PAD : S_FCS;
`else
    assign data_done = S_FCS;
`endif

    always_ff @(posedge clk125In or posedge rstIn) begin
        if (rstIn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            crc_q   <= '1;
            byte_q  <= '0;
            en_q    <= 1'b0;
            fall_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            crc_q   <= crc_d;
            byte_q  <= byte_d;
            en_q    <= en_d;
            fall_q  <= en_d ^ er_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            under_q <= under_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = (PRE_L > 16'd1) ? S_PRE : S_SFD;
            S_PRE:   if (cnt_q == PRE_L - 16'd2) state_d = S_SFD;
            S_SFD:   state_d = S_DATA;
            S_DATA:  state_d = !txDataValidIn ? S_ERR : txDataLastIn ? data_done : S_DATA;
`ifdef RGMII_TX_PAD_EN
            S_PAD:   if (len_inc >= MIN_L) state_d = S_FCS;
`endif
            S_FCS:   if (cnt_q == 16'd3) state_d = S_IFG;
            S_IFG:   if (cnt_q == IFG_L - 16'd1) state_d = S_IDLE;
            S_ERR:   state_d = S_DRAIN;
            S_DRAIN: if (txDataValidIn & txDataLastIn) state_d = S_IFG;
            default: state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    end

    // Outputs are one cycle behind the state that decides them, so the IDLE
    // cycle that starts a frame already launches the first preamble byte.
    always_comb begin
        byte_d  = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
        under_d = 1'b0;
        crc_d   = crc_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                crc_d  = '1;
                len_d  = '0;
                en_d   = go;
                byte_d = go ? 8'h55 : 8'h00;
            end
            S_PRE: begin
                en_d   = 1'b1;
                byte_d = 8'h55;
            end
            S_SFD: begin
                en_d   = 1'b1;
                byte_d = 8'hD5;
            end
            S_DATA: begin
                en_d    = 1'b1;
                er_d    = !txDataValidIn;
                under_d = !txDataValidIn;
                byte_d  = txDataValidIn ? txDataIn : 8'h00;
                crc_d   = txDataValidIn ? crc_byte(crc_q, txDataIn) : crc_q;
                len_d   = txDataValidIn ? len_inc : len_q;
            end
`ifdef RGMII_TX_PAD_EN
            S_PAD: begin
                en_d  = 1'b1;
                crc_d = crc_byte(crc_q, 8'h00);
                len_d = len_inc;
            end
`endif
            S_FCS: begin
                en_d   = 1'b1;
                byte_d = 8'(~crc_q >> {cnt_q[1:0], 3'b000});
            end
            default: ;
        endcase
        ready_d = (state_d == S_DATA) || (state_d == S_DRAIN);
        busy_d  = state_d != S_IDLE;
    end

    assign txReadyOut    = ready_q;
    assign txDataRiseOut = byte_q[3:0];
    assign txDataFallOut = byte_q[7:4];
    assign txCtrlRiseOut = en_q;
    assign txCtrlFallOut = fall_q;
    assign txBusyOut     = busy_q;
    assign txUnderrunOut = under_q;
endmodule
